prince_share_driver: RTL and testbench
======================================

Name: prince_share_driver

Overview:
- Host-side initiator for the two-share PRINCE encryption/decryption core.
- Accepts an unmasked 64-bit block, a 128-bit key, a direction bit and a 64-bit mask over a valid/ready handshake.
- Splits the block into two Boolean shares, sequences the core's rst/en/done protocol and recombines the core's two output shares.
- Returns the unmasked result on a valid/ready output port, with a watchdog on the core's latency.

Parameters:
- MAX_CYCLES, 63: cycles allowed from core_en assertion to core_done before the transaction aborts with an error.
- CNT_W, 6: width of the watchdog counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  driver can accept a transaction.
- in_data  in  64  unmasked plaintext/ciphertext.
- in_key  in  128  key, passed through unchanged to core_k.
- in_enc  in  1  1 = encrypt, 0 = decrypt.
- in_mask  in  64  fresh mask for share splitting.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  64  unmasked result, core_c0 ^ core_c1.
- out_err  out  1  qualifies out_valid; 1 = watchdog timeout, and out_data is 0.
- core_rst  out  1  reset to the core.
- core_en  out  1  enable to the core.
- core_enc  out  1  direction to the core.
- core_p0  out  64  share 0 = in_data ^ in_mask, registered.
- core_p1  out  64  share 1 = in_mask, registered.
- core_k  out  128  registered key.
- core_c0  in  64  core output share 0.
- core_c1  in  64  core output share 1.
- core_done  in  1  core result valid.

Behaviour:
- Reset:
  - Synchronous, active-high, on clk only.
  - Clears state to IDLE and the counter to 0.
  - Reset values: in_ready=0 during rst, then 1 in IDLE; out_valid=0, out_err=0, out_data=0; core_en=0, core_rst=1 while rst=1; core_p0/p1/k/enc all 0.
  - rst asserted mid-transaction discards the transaction; no output is produced.
- States: IDLE, ARM, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register core_p0 = in_data^in_mask, core_p1 = in_mask, core_k, core_enc; go to ARM.
  - The unmasked in_data is never registered.
- ARM:
  - Exactly one cycle with core_rst=1, core_en=0; clear counter; go to RUN.
- RUN:
  - core_en=1; core_p0/p1/k/enc held stable.
  - Counter increments every cycle.
  - core_done=1 has priority over timeout when both occur in the same cycle. On core_done=1: register out_data = core_c0^core_c1, out_err=0; core_en drops the next cycle; go to HOLD.
  - Otherwise, counter == MAX_CYCLES-1: out_data=0, out_err=1; go to HOLD.
- HOLD:
  - out_valid=1; out_data and out_err stable; core_en=0.
  - On out_ready: out_valid drops the next cycle; core_p0/p1 cleared to 0; go to IDLE.
- Latency: accept at cycle 0, core_en rises at cycle 2, out_valid rises 1 cycle after core_done.
- Throughput: one transaction in flight; in_ready=0 outside IDLE.
- Simultaneous out handshake and new in_valid: no bypass. The next accept occurs in the IDLE cycle that follows.
- Counter: saturating; it never wraps within RUN.

Decomposition:
- Shared package prince_pkg:
  - state enum (IDLE/ARM/RUN/HOLD);
  - BLOCK_W=64, KEY_W=128 constants;
  - known-answer test vectors.
- No sub-module is natural beyond the existing register_stage64, which is reused for the core_p0/core_p1 share registers.

Test Plan:
- Encrypt KAT: in_data=0, in_key=0, in_enc=1, in_mask=0x0123456789ABCDEF -> core_p0=0x0123456789ABCDEF, core_p1=0x0123456789ABCDEF; out_data=0x818665AA0D02DFDA, out_err=0.
- Encrypt KAT, second vector: in_data=0xFFFFFFFFFFFFFFFF, key=0, mask=0xA5A5A5A5A5A5A5A5 -> out_data=0x604AE6CA03C20ADA.
- Decrypt round trip: in_data=0x818665AA0D02DFDA, key=0, in_enc=0 -> out_data=0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid stays 1, out_data stable, in_ready=0, core_en=0; one out_ready pulse -> out_valid=0 and in_ready=1 the next cycle.
- Timeout: core_done tied 0 -> out_valid=1 with out_err=1, out_data=0 exactly MAX_CYCLES cycles after core_en rises.
- Reset mid-RUN: rst for 1 cycle at RUN cycle 5 -> the next cycle shows IDLE, core_en=0, out_valid=0; no stale result appears after a new transaction.

Source files
------------

// File: rtl/prince_pkg.sv
// Shared types and constants for the two-share PRINCE host driver.
// Holds the FSM state encoding, datapath widths and known-answer vectors.
package prince_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Reference PRINCE vectors, all with an all-zero 128-bit key.
  localparam logic [KEY_W-1:0]   KAT_KEY   = '0;
  localparam logic [BLOCK_W-1:0] KAT0_PT   = 64'h0000000000000000;
  localparam logic [BLOCK_W-1:0] KAT0_CT   = 64'h818665AA0D02DFDA;
  localparam logic [BLOCK_W-1:0] KAT0_MASK = 64'h0123456789ABCDEF;
  localparam logic [BLOCK_W-1:0] KAT1_PT   = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [BLOCK_W-1:0] KAT1_CT   = 64'h604AE6CA03C20ADA;
  localparam logic [BLOCK_W-1:0] KAT1_MASK = 64'hA5A5A5A5A5A5A5A5;

endpackage

// File: rtl/prince_share_driver_if.sv
// Host-side request/response bundle of the PRINCE share driver.
// The host drives the request and out_ready; the driver answers on the rest.
interface prince_share_driver_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [prince_pkg::BLOCK_W-1:0] in_data;
  logic [prince_pkg::KEY_W-1:0]   in_key;
  logic                          in_enc;
  logic [prince_pkg::BLOCK_W-1:0] in_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [prince_pkg::BLOCK_W-1:0] out_data;
  logic                          out_err;

  modport master (
    output in_valid, in_data, in_key, in_enc, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_key, in_enc, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/register_stage64.sv
// 64-bit register with synchronous reset, load and clear; load wins over clear.
module register_stage64
  import prince_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [BLOCK_W-1:0] d,
  output logic [BLOCK_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= d;
    else if (clear) q <= '0;
  end

endmodule

// File: rtl/prince_share_driver.sv
// Host initiator for the two-share PRINCE core: masks the block into shares,
// runs the core's rst/en/done protocol under a watchdog, and unmasks the result.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// ARM   | one-cycle core reset, watchdog cleared
// RUN   | core enabled, waiting for core_done or watchdog expiry
// HOLD  | result presented until out_ready
module prince_share_driver
  import prince_pkg::*;
#(
  parameter int MAX_CYCLES = 63,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  prince_share_driver_if.slave host,
  output logic                 core_rst,
  output logic                 core_en,
  output logic                 core_enc,
  output logic [BLOCK_W-1:0]   core_p0,
  output logic [BLOCK_W-1:0]   core_p1,
  output logic [KEY_W-1:0]     core_k,
  input  logic [BLOCK_W-1:0]   core_c0,
  input  logic [BLOCK_W-1:0]   core_c1,
  input  logic                 core_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               release_out;
  logic               done_hit;
  logic               timeout;
  logic [BLOCK_W-1:0] res_data;
  logic               res_err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    core_en       = 1'b0;
    core_rst      = rst;
    case (state)
      IDLE: begin
        host.in_ready = !rst;
        if (host.in_valid) state_nx = ARM;
      end
      ARM: begin
        core_rst = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        core_en = !rst;
        if (core_done || cnt == CNT_LAST) state_nx = HOLD;
      end
      HOLD: begin
        host.out_valid = !rst;
        if (host.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept      = (state == IDLE) && host.in_valid;
  assign release_out = (state == HOLD) && host.out_ready;
  // A done arriving on the last watchdog cycle still counts as success.
  assign done_hit    = (state == RUN) && core_done;
  assign timeout     = (state == RUN) && !core_done && (cnt == CNT_LAST);

  // Saturates rather than wrapping so an oversized MAX_CYCLES cannot alias.
  always_ff @(posedge clk) begin
    if (rst)                               cnt <= '0;
    else if (state == ARM)                 cnt <= '0;
    else if (state == RUN && cnt != '1)    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (done_hit) begin
      res_data <= core_c0 ^ core_c1;
      res_err  <= 1'b0;
    end else if (timeout) begin
      res_data <= '0;
      res_err  <= 1'b1;
    end
  end

  assign host.out_data = res_data;
  assign host.out_err  = res_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_k   <= '0;
      core_enc <= 1'b0;
    end else if (accept) begin
      core_k   <= host.in_key;
      core_enc <= host.in_enc;
    end
  end

  // Only the masked share is stored; the plain block never reaches a flop.
  register_stage64 u_share0 (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .clear (release_out),
    .d     (host.in_data ^ host.in_mask),
    .q     (core_p0)
  );

  register_stage64 u_share1 (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .clear (release_out),
    .d     (host.in_mask),
    .q     (core_p1)
  );

endmodule

// File: tb/tb_prince_share_driver.sv
// Scoreboard bench for prince_share_driver with a behavioural two-share core.
// Expected results are queued at accept and popped by an independent monitor.
module tb_prince_share_driver;
  import prince_pkg::*;

  localparam int MAXC = 63;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, core_en, core_enc, core_done;
  logic [63:0]  core_p0, core_p1, core_c0, core_c1;
  logic [127:0] core_k;

  prince_share_driver_if bus ();

  prince_share_driver #(.MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus),
    .core_rst  (core_rst),
    .core_en   (core_en),
    .core_enc  (core_enc),
    .core_p0   (core_p0),
    .core_p1   (core_p1),
    .core_k    (core_k),
    .core_c0   (core_c0),
    .core_c1   (core_c1),
    .core_done (core_done)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   core_lat = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for PRINCE: exact on the reference vectors, invertible toy elsewhere.
  function automatic logic [63:0] ref_cipher(input logic [63:0] x, input logic [127:0] k, input logic e);
    logic [63:0] t;
    if (k == KAT_KEY) begin
      if (e && x == KAT0_PT)  return KAT0_CT;
      if (e && x == KAT1_PT)  return KAT1_CT;
      if (!e && x == KAT0_CT) return KAT0_PT;
      if (!e && x == KAT1_CT) return KAT1_PT;
    end
    if (e) begin
      t = x ^ k[127:64];
      return {t[50:0], t[63:51]} ^ k[63:0];
    end
    t = x ^ k[63:0];
    return {t[12:0], t[63:13]} ^ k[127:64];
  endfunction

  // Core model: counts enabled cycles since its reset and fires done once.
  initial begin
    int   seen;
    bit   fired;
    logic [63:0] r;
    seen = 0; fired = 0;
    core_done = 1'b0; core_c0 = '0; core_c1 = '0;
    forever begin
      @(posedge clk); #2;
      core_done = 1'b0;
      core_c0 = {$urandom, $urandom};
      core_c1 = {$urandom, $urandom};
      if (core_rst) begin
        seen = 0; fired = 0;
      end else if (core_en && !fired) begin
        seen++;
        if (seen == core_lat) begin
          r = {$urandom, $urandom};
          core_c1   = r;
          core_c0   = ref_cipher(core_p0 ^ core_p1, core_k, core_enc) ^ r;
          core_done = 1'b1;
          fired     = 1;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out: got data %h err %0b with nothing expected", bus.out_data, bus.out_err);
        end else begin
          e = sb.pop_front();
          check("out_data", {64'h0, bus.out_data}, {64'h0, e.data});
          check("out_err", {127'h0, bus.out_err}, {127'h0, e.err});
        end
      end
    end
  end

  function automatic exp_t model(input logic [63:0] d, input logic [127:0] k, input logic e, input int lat);
    exp_t x;
    x.err  = (lat > MAXC);
    x.data = x.err ? 64'h0 : ref_cipher(d, k, e);
    return x;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [127:0] k, input logic e,
                      input logic [63:0] m, input int lat);
    bit ok;
    ok = 0;
    core_lat     = lat;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_key   = k;
    bus.in_enc   = e;
    bus.in_mask  = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        sb.push_back(model(d, k, e, lat));
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
    bus.in_mask  = {$urandom, $urandom};
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(input bit random_bp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      bus.out_ready = random_bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) seen = 1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    if (!seen) check("result_timeout", 0, 1);
  endtask

  task automatic wait_core_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_en) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("core_en_timeout", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [63:0]  d, m, held;
    logic [127:0] k;
    bit           ok;
    int           n, lat;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_key = '0;
    bus.in_enc = 1'b0; bus.in_mask = '0; bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_core_en", core_en, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_p0", core_p0, 0);
    check("rst_core_p1", core_p1, 0);
    check("rst_core_k", core_k, 0);
    check("rst_core_enc", core_enc, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_core_rst", core_rst, 0);
    @(posedge clk); #1;

    // Encrypt KAT with share and ARM/RUN timing checks
    send(KAT0_PT, KAT_KEY, 1'b1, KAT0_MASK, 5);
    @(negedge clk);
    check("arm_core_rst", core_rst, 1);
    check("arm_core_en", core_en, 0);
    check("arm_in_ready", bus.in_ready, 0);
    check("kat0_p0", core_p0, 64'h0123456789ABCDEF);
    check("kat0_p1", core_p1, 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("run_core_en", core_en, 1);
    check("run_core_rst", core_rst, 0);
    check("run_core_enc", core_enc, 1);
    @(posedge clk); #1;
    wait_result(0);
    @(negedge clk);
    check("post_p0_cleared", core_p0, 0);
    check("post_p1_cleared", core_p1, 0);
    @(posedge clk); #1;

    send(KAT1_PT, KAT_KEY, 1'b1, KAT1_MASK, $urandom_range(1, 20));
    @(negedge clk);
    check("kat1_p0", core_p0, KAT1_PT ^ KAT1_MASK);
    check("kat1_p1", core_p1, KAT1_MASK);
    @(posedge clk); #1;
    wait_result(0);

    send(KAT0_CT, KAT_KEY, 1'b0, {$urandom, $urandom}, $urandom_range(1, 20));
    wait_result(1);

    // Backpressure, then an out handshake overlapping a new request
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom}, 3);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) check("bp_valid_timeout", 0, 1);
    @(negedge clk);
    held = bus.out_data;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_core_en", core_en, 0);
      @(posedge clk); #1;
    end
    d = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; m = {$urandom, $urandom};
    core_lat = 4;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_key = k; bus.in_enc = 1'b0; bus.in_mask = m;
    @(negedge clk);
    check("nobypass_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("after_pulse_out_valid", bus.out_valid, 0);
    check("after_pulse_in_ready", bus.in_ready, 1);
    if (bus.in_ready) sb.push_back(model(d, k, 1'b0, 4));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(0);

    // Watchdog: exact timeout distance from core_en rising
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1000);
    wait_core_en(ok);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("timeout_cycles", n, MAXC);
    check("timeout_err", bus.out_err, 1);
    check("timeout_data", bus.out_data, 0);
    @(posedge clk); #1;
    wait_result(0);

    // done on the last watchdog cycle wins; one cycle later times out
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom}, MAXC);
    wait_result(0);
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, {$urandom, $urandom}, MAXC + 1);
    wait_result(1);

    // Reset during RUN cycle 5 discards the transaction
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom}, 30);
    wait_core_en(ok);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_core_en", core_en, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom}, 4);
    wait_result(0);

    // Randomized traffic, including occasional watchdog expiries
    for (int t = 0; t < 40; t++) begin
      lat = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, 40);
      send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), {$urandom, $urandom}, lat);
      wait_result(1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
